// File: rtl/viterbi_pkg.sv
// Shared types and constants for the Viterbi decoder frame control path.
package viterbi_pkg;

  // Frame sequencer states.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    INIT  = 3'd1,
    ACS   = 3'd2,
    TRACE = 3'd3,
    OUT   = 3'd4,
    DONE  = 3'd5
  } vit_state_t;

  // Initial path metrics: state 0 starts at zero, the other states start at the
  // worst value so the first decisions favour the all-zero encoder start.
  localparam logic [1:0] PM_INIT_S0 = 2'b00;
  localparam logic [1:0] PM_INIT_SX = 2'b11;

endpackage

// File: rtl/vit_mod_counter.sv
// Up/down address counter with synchronous load, enable and terminal-count flag.
// Terminal count is MAX when counting up and zero when counting down; the owner
// reloads the counter at the terminal count, so it never wraps.
module vit_mod_counter #(
  parameter int unsigned W   = 4,
  parameter int unsigned MAX = 15
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  input  logic         up,
  output logic [W-1:0] cnt,
  output logic         tc
);

  localparam logic [W-1:0] MAX_V = W'(MAX);

  // Count register; load takes priority over enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en) begin
      cnt <= up ? (cnt + W'(1)) : (cnt - W'(1));
    end
  end

  // Terminal count in the active counting direction.
  assign tc = up ? (cnt == MAX_V) : (cnt == '0);

endmodule

// File: rtl/viterbi_frame_ctrl.sv
// Frame-level sequencer for the K=3 hard-decision Viterbi decoder: symbol intake,
// path-metric bank control, survivor write/read addressing and decoded-bit output.
module viterbi_frame_ctrl
  import viterbi_pkg::*;
#(
  parameter int unsigned FRAME_LEN = 16,
  parameter int unsigned ADDR_W    = $clog2(FRAME_LEN)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_sym_valid,
  output logic              o_sym_ready,
  output logic              o_pm_init,
  output logic              o_pm_valid,
  output logic              o_sm_wr_en,
  output logic [ADDR_W-1:0] o_sm_wr_addr,
  output logic              o_tb_en,
  output logic              o_tb_first,
  output logic [ADDR_W-1:0] o_tb_addr,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic [ADDR_W-1:0] o_out_addr,
  output logic              o_out_last,
  output logic              o_busy,
  output logic              o_done
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_LEN - 1);

  vit_state_t state, state_nx;

  logic [ADDR_W-1:0] sym_cnt, tb_cnt, out_cnt;
  logic              sym_tc, tb_tc, out_tc;
  logic              sym_ld, sym_en;
  logic              tb_ld, tb_cnt_en;
  logic              out_ld, out_cnt_en;

  // Survivor write address: counts accepted symbols upward.
  vit_mod_counter #(.W(ADDR_W), .MAX(FRAME_LEN - 1)) u_sym_cnt (
    .clk      (i_clk),
    .rst_n    (i_rst_n),
    .load     (sym_ld),
    .load_val ('0),
    .en       (sym_en),
    .up       (1'b1),
    .cnt      (sym_cnt),
    .tc       (sym_tc)
  );

  // Traceback read address: walks the survivor memory newest to oldest.
  vit_mod_counter #(.W(ADDR_W), .MAX(FRAME_LEN - 1)) u_tb_cnt (
    .clk      (i_clk),
    .rst_n    (i_rst_n),
    .load     (tb_ld),
    .load_val (LAST_ADDR),
    .en       (tb_cnt_en),
    .up       (1'b0),
    .cnt      (tb_cnt),
    .tc       (tb_tc)
  );

  // Reversal buffer read address: advances on each output handshake.
  vit_mod_counter #(.W(ADDR_W), .MAX(FRAME_LEN - 1)) u_out_cnt (
    .clk      (i_clk),
    .rst_n    (i_rst_n),
    .load     (out_ld),
    .load_val ('0),
    .en       (out_cnt_en),
    .up       (1'b1),
    .cnt      (out_cnt),
    .tc       (out_tc)
  );

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state, counter control and output decode.
  always_comb begin
    state_nx     = state;
    sym_ld       = 1'b0;
    sym_en       = 1'b0;
    tb_ld        = 1'b0;
    tb_cnt_en    = 1'b0;
    out_ld       = 1'b0;
    out_cnt_en   = 1'b0;
    o_sym_ready  = 1'b0;
    o_pm_init    = 1'b0;
    o_pm_valid   = 1'b0;
    o_sm_wr_en   = 1'b0;
    o_sm_wr_addr = '0;
    o_tb_en      = 1'b0;
    o_tb_first   = 1'b0;
    o_tb_addr    = '0;
    o_out_valid  = 1'b0;
    o_out_addr   = '0;
    o_out_last   = 1'b0;
    o_busy       = (state != IDLE);
    o_done       = 1'b0;

    case (state)
      IDLE: begin
        if (i_start) begin
          state_nx = INIT;
        end
      end

      INIT: begin
        o_pm_init = 1'b1;
        o_pm_valid = 1'b1;
        sym_ld = 1'b1;
        state_nx = ACS;
      end

      ACS: begin
        o_sym_ready  = 1'b1;
        o_sm_wr_addr = sym_cnt;
        if (i_sym_valid) begin
          o_pm_valid = 1'b1;
          o_sm_wr_en = 1'b1;
          if (sym_tc) begin
            sym_ld   = 1'b1;
            tb_ld    = 1'b1;
            state_nx = TRACE;
          end else begin
            sym_en = 1'b1;
          end
        end
      end

      TRACE: begin
        o_tb_en    = 1'b1;
        o_tb_addr  = tb_cnt;
        o_tb_first = (tb_cnt == LAST_ADDR);
        if (tb_tc) begin
          out_ld   = 1'b1;
          state_nx = OUT;
        end else begin
          tb_cnt_en = 1'b1;
        end
      end

      OUT: begin
        o_out_valid = 1'b1;
        o_out_addr  = out_cnt;
        o_out_last  = out_tc;
        if (i_out_ready) begin
          if (out_tc) begin
            out_ld   = 1'b1;
            state_nx = DONE;
          end else begin
            out_cnt_en = 1'b1;
          end
        end
      end

      DONE: begin
        o_done   = 1'b1;
        state_nx = IDLE;
      end

      default: begin
        state_nx = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_viterbi_frame_ctrl.sv
// Randomized self-checking bench for viterbi_frame_ctrl with a transaction-level
// frame model: k-th accepted symbol writes address k, traceback reads FL-1 down to 0,
// n-th output bit reads address n, then one DONE cycle and back to idle.
module tb_viterbi_frame_ctrl;

  localparam int unsigned FL = 4;
  localparam int unsigned AW = $clog2(FL);
  localparam int BUDGET = 200;

  logic          i_clk = 1'b0;
  logic          i_rst_n = 1'b0;
  logic          i_start = 1'b0;
  logic          i_sym_valid = 1'b0;
  logic          i_out_ready = 1'b0;
  logic          o_sym_ready, o_pm_init, o_pm_valid, o_sm_wr_en;
  logic          o_tb_en, o_tb_first, o_out_valid, o_out_last, o_busy, o_done;
  logic [AW-1:0] o_sm_wr_addr, o_tb_addr, o_out_addr;

  int checks = 0;
  int errors = 0;
  bit vpat[$];
  bit rpat[$];

  viterbi_frame_ctrl #(.FRAME_LEN(FL)) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_start      (i_start),
    .i_sym_valid  (i_sym_valid),
    .o_sym_ready  (o_sym_ready),
    .o_pm_init    (o_pm_init),
    .o_pm_valid   (o_pm_valid),
    .o_sm_wr_en   (o_sm_wr_en),
    .o_sm_wr_addr (o_sm_wr_addr),
    .o_tb_en      (o_tb_en),
    .o_tb_first   (o_tb_first),
    .o_tb_addr    (o_tb_addr),
    .o_out_valid  (o_out_valid),
    .i_out_ready  (i_out_ready),
    .o_out_addr   (o_out_addr),
    .o_out_last   (o_out_last),
    .o_busy       (o_busy),
    .o_done       (o_done)
  );

  always #5 i_clk = ~i_clk;

  function automatic logic [3*AW+9:0] all_outs();
    return {o_sym_ready, o_pm_init, o_pm_valid, o_sm_wr_en, o_tb_en, o_tb_first,
            o_out_valid, o_out_last, o_busy, o_done, o_sm_wr_addr, o_tb_addr, o_out_addr};
  endfunction

  // mode 0: always 1, mode 1: from pattern queue (1 once exhausted), mode 2: random
  function automatic bit pick(input int mode, input bit for_valid);
    bit b;
    b = 1'b1;
    if (mode == 1) begin
      if (for_valid && vpat.size() > 0) b = vpat.pop_front();
      else if (!for_valid && rpat.size() > 0) b = rpat.pop_front();
    end else if (mode == 2) begin
      b = 1'($urandom_range(0, 1));
    end
    return b;
  endfunction

  // One full frame checked against the frame model; abort_addr >= 0 drops reset
  // during traceback at that read address.
  task automatic drive_frame(input int v_mode, input int r_mode, input bit noise,
                             input int abort_addr);
    int k, n, budget;
    bit v, r;
    // start from idle
    @(negedge i_clk);
    i_start = 1'b1;
    i_sym_valid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
    i_out_ready = noise ? 1'($urandom_range(0, 1)) : 1'b0;
    #1;
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL idle_busy got %b want 0", o_busy); end
    checks++; if (o_sym_ready !== 1'b0) begin errors++; $display("FAIL idle_ready got %b want 0", o_sym_ready); end
    // init cycle
    @(negedge i_clk);
    i_start = 1'b0;
    #1;
    checks++; if (o_pm_init !== 1'b1) begin errors++; $display("FAIL init_pm_init got %b want 1", o_pm_init); end
    checks++; if (o_pm_valid !== 1'b1) begin errors++; $display("FAIL init_pm_valid got %b want 1", o_pm_valid); end
    checks++; if (o_sym_ready !== 1'b0) begin errors++; $display("FAIL init_ready got %b want 0", o_sym_ready); end
    checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL init_busy got %b want 1", o_busy); end
    // symbol intake
    k = 0;
    budget = 0;
    while (k < int'(FL) && budget < BUDGET) begin
      @(negedge i_clk);
      v = pick(v_mode, 1'b1);
      i_sym_valid = v;
      i_start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      #1;
      checks++; if (o_sym_ready !== 1'b1) begin errors++; $display("FAIL acs_ready got %b want 1", o_sym_ready); end
      checks++; if (o_pm_valid !== v) begin errors++; $display("FAIL acs_pm_valid got %b want %b", o_pm_valid, v); end
      checks++; if (o_sm_wr_en !== v) begin errors++; $display("FAIL acs_wr_en got %b want %b", o_sm_wr_en, v); end
      checks++; if (o_pm_init !== 1'b0) begin errors++; $display("FAIL acs_pm_init got %b want 0", o_pm_init); end
      if (v) begin
        checks++;
        if (o_sm_wr_addr !== AW'(k)) begin errors++; $display("FAIL acs_wr_addr got %0d want %0d", o_sm_wr_addr, k); end
        k++;
      end
      budget++;
    end
    checks++; if (budget >= BUDGET) begin errors++; $display("FAIL acs_timeout accepted %0d want %0d", k, FL); end
    // traceback
    for (int j = 0; j < int'(FL); j++) begin
      @(negedge i_clk);
      i_sym_valid = 1'($urandom_range(0, 1));
      i_start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      #1;
      checks++; if (o_tb_en !== 1'b1) begin errors++; $display("FAIL tb_en got %b want 1", o_tb_en); end
      checks++; if (o_tb_addr !== AW'(int'(FL) - 1 - j)) begin errors++; $display("FAIL tb_addr got %0d want %0d", o_tb_addr, int'(FL) - 1 - j); end
      checks++; if (o_tb_first !== (j == 0)) begin errors++; $display("FAIL tb_first got %b want %b", o_tb_first, (j == 0)); end
      checks++; if (o_sym_ready !== 1'b0) begin errors++; $display("FAIL tb_ready got %b want 0", o_sym_ready); end
      checks++; if (o_pm_valid !== 1'b0) begin errors++; $display("FAIL tb_pm_valid got %b want 0", o_pm_valid); end
      if (abort_addr == int'(FL) - 1 - j) begin
        i_rst_n = 1'b0;
        #1;
        checks++; if (all_outs() !== '0) begin errors++; $display("FAIL async_reset_outs got %h want 0", all_outs()); end
        @(negedge i_clk);
        i_rst_n = 1'b1;
        i_start = 1'b0;
        i_sym_valid = 1'b0;
        #1;
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL post_reset_busy got %b want 0", o_busy); end
        return;
      end
    end
    i_sym_valid = 1'b0;
    // output metering
    n = 0;
    budget = 0;
    while (n < int'(FL) && budget < BUDGET) begin
      @(negedge i_clk);
      r = pick(r_mode, 1'b0);
      i_out_ready = r;
      i_start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      #1;
      checks++; if (o_out_valid !== 1'b1) begin errors++; $display("FAIL out_valid got %b want 1", o_out_valid); end
      checks++; if (o_out_addr !== AW'(n)) begin errors++; $display("FAIL out_addr got %0d want %0d", o_out_addr, n); end
      checks++; if (o_out_last !== (n == int'(FL) - 1)) begin errors++; $display("FAIL out_last got %b want %b", o_out_last, (n == int'(FL) - 1)); end
      checks++; if (o_tb_en !== 1'b0) begin errors++; $display("FAIL out_tb_en got %b want 0", o_tb_en); end
      if (r) n++;
      budget++;
    end
    checks++; if (budget >= BUDGET) begin errors++; $display("FAIL out_timeout sent %0d want %0d", n, FL); end
    // done pulse, start here must be ignored
    @(negedge i_clk);
    i_start = noise;
    i_out_ready = 1'($urandom_range(0, 1));
    #1;
    checks++; if (o_done !== 1'b1) begin errors++; $display("FAIL done_pulse got %b want 1", o_done); end
    checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL done_busy got %b want 1", o_busy); end
    checks++; if (o_out_valid !== 1'b0) begin errors++; $display("FAIL done_out_valid got %b want 0", o_out_valid); end
    // back in idle for two cycles
    for (int j = 0; j < 2; j++) begin
      @(negedge i_clk);
      i_start = 1'b0;
      i_out_ready = 1'b0;
      #1;
      checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL after_done_busy got %b want 0", o_busy); end
      checks++; if (o_done !== 1'b0) begin errors++; $display("FAIL after_done_done got %b want 0", o_done); end
    end
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0;
    repeat (2) @(negedge i_clk);
    #1;
    checks++; if (all_outs() !== '0) begin errors++; $display("FAIL reset_outs got %h want 0", all_outs()); end
    i_rst_n = 1'b1;
    i_sym_valid = 1'b1;
    i_out_ready = 1'b1;
    @(negedge i_clk);
    #1;
    checks++; if (all_outs() !== '0) begin errors++; $display("FAIL idle_ignores_inputs got %h want 0", all_outs()); end
    i_sym_valid = 1'b0;
    i_out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    drive_frame(0, 0, 1'b0, -1);
  endtask

  task automatic test_sym_gaps();
    vpat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    drive_frame(1, 0, 1'b0, -1);
  endtask

  task automatic test_out_backpressure();
    rpat = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    drive_frame(0, 1, 1'b0, -1);
  endtask

  task automatic test_start_ignored();
    drive_frame(0, 0, 1'b1, -1);
  endtask

  task automatic test_reset_mid_trace();
    drive_frame(0, 0, 1'b0, 2);
    drive_frame(0, 0, 1'b0, -1);
  endtask

  task automatic test_random();
    repeat (6) drive_frame(2, 2, 1'b1, -1);
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_sym_gaps();
    test_out_backpressure();
    test_start_ignored();
    test_reset_mid_trace();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
